// File: rtl/scan_key_if.sv
// Bundle between the test-port serial feeder and the scan key deserializer:
// serial key bits in, assembled key words and unlock/lockout status out.
interface scan_key_if #(
    parameter int KEY_WIDTH = 32,
    parameter int MAX_WORDS = 12
);
    localparam int WC_W = $clog2(MAX_WORDS + 1);

    logic                 key_sin;
    logic                 key_shift;
    logic                 key_abort;
    logic                 scan_unlock;
    logic [KEY_WIDTH-1:0] scan_key;
    logic                 key_word_valid;
    logic [WC_W-1:0]      word_count;
    logic                 locked;
    logic                 unlocked;

    modport master (
        output key_sin, key_shift, key_abort, scan_unlock,
        input  scan_key, key_word_valid, word_count, locked, unlocked
    );

    modport slave (
        input  key_sin, key_shift, key_abort, scan_unlock,
        output scan_key, key_word_valid, word_count, locked, unlocked
    );
endinterface

// File: rtl/scan_key_deserializer.sv
// Serial-to-word key deserializer feeding the scan unlock comparator (MSB first).
// Optional word-budget lockout is enabled by defining SCAN_KEY_LOCKOUT_EN.
module scan_key_deserializer #(
    parameter int                   KEY_WIDTH = 32,
    parameter int                   MAX_WORDS = 12,
    parameter logic [KEY_WIDTH-1:0] IDLE_WORD = '0
) (
    input logic       clk,
    input logic       rst_n,
    scan_key_if.slave kif
);
    localparam int               CNT_W    = $clog2(KEY_WIDTH) + 1;
    localparam int               WC_W     = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_WIDTH - 1);
    localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(MAX_WORDS);

`ifdef SCAN_KEY_LOCKOUT_EN
    typedef enum logic [1:0] {SHIFT, DONE, LOCKED} state_t;
`else
    typedef enum logic [1:0] {SHIFT, DONE} state_t;
`endif

    state_t               state;
    logic [KEY_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [KEY_WIDTH-1:0] key_p0;
    logic                 vld_p0;
    logic [WC_W-1:0]      wc;
    logic                 unl_r;
`ifdef SCAN_KEY_LOCKOUT_EN
    logic                 lock_r;
`endif

    // Shift one bit in at the LSB; written without a part-select so KEY_WIDTH=1 works.
    function automatic logic [KEY_WIDTH-1:0] shift_in(input logic [KEY_WIDTH-1:0] sr,
                                                      input logic b);
        return (sr << 1) | KEY_WIDTH'(b);
    endfunction

    function automatic logic [WC_W-1:0] sat_inc(input logic [WC_W-1:0] c);
        return (c == WC_MAX) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SHIFT;
            shreg   <= '0;
            bit_cnt <= '0;
            key_p0  <= IDLE_WORD;
            vld_p0  <= 1'b0;
            wc      <= '0;
            unl_r   <= 1'b0;
`ifdef SCAN_KEY_LOCKOUT_EN
            lock_r  <= 1'b0;
`endif
        end else begin
            // Output word is a single-cycle event; idle unless a word completes now.
            key_p0 <= IDLE_WORD;
            vld_p0 <= 1'b0;
            case (state)
                SHIFT: begin
                    if (kif.scan_unlock) begin
                        state   <= DONE;
                        unl_r   <= 1'b1;
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end
`ifdef SCAN_KEY_LOCKOUT_EN
                    else if ((wc == WC_MAX) && !unl_r && kif.key_shift) begin
                        state  <= LOCKED;
                        lock_r <= 1'b1;
                    end
`endif
                    else if (kif.key_abort) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end else if (kif.key_shift) begin
                        shreg <= shift_in(shreg, kif.key_sin);
                        if (bit_cnt == LAST_BIT) begin
                            key_p0  <= shift_in(shreg, kif.key_sin);
                            vld_p0  <= 1'b1;
                            bit_cnt <= '0;
                            wc      <= sat_inc(wc);
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign kif.scan_key       = key_p0;
    assign kif.key_word_valid = vld_p0;
    assign kif.word_count     = wc;
    assign kif.unlocked       = unl_r;
`ifdef SCAN_KEY_LOCKOUT_EN
    assign kif.locked         = lock_r;
`else
    assign kif.locked         = 1'b0;
`endif
endmodule

// File: tb/tb_scan_key_deserializer.sv
// Self-checking bench for scan_key_deserializer: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_scan_key_deserializer;
    localparam int            KW   = 32;
    localparam int            MW   = 12;
    localparam logic [KW-1:0] IDLE = '0;
`ifdef SCAN_KEY_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_valid = 0;
    int   vq[$];

    scan_key_if #(.KEY_WIDTH(KW), .MAX_WORDS(MW)) kif();

    scan_key_deserializer #(.KEY_WIDTH(KW), .MAX_WORDS(MW), .IDLE_WORD(IDLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    always #5 clk = ~clk;

    // Reference model: bits collected in a queue, a word emitted once KW bits arrive.
    bit            m_done, m_locked, m_unl, m_vld;
    logic          m_q[$];
    logic [KW-1:0] m_key;
    int            m_wc;

    function automatic void m_reset();
        m_done = 0; m_locked = 0; m_unl = 0; m_vld = 0;
        m_q.delete(); m_key = IDLE; m_wc = 0;
    endfunction

    function automatic void model_step(input logic sin, input logic sh,
                                       input logic ab, input logic un);
        logic [KW-1:0] w;
        m_vld = 0;
        m_key = IDLE;
        if (m_done || m_locked) return;
        if (un) begin
            m_done = 1; m_unl = 1; m_q.delete();
        end else if (LOCKOUT && m_wc == MW && sh) begin
            m_locked = 1;
        end else if (ab) begin
            m_q.delete();
        end else if (sh) begin
            m_q.push_back(sin);
            if (m_q.size() == KW) begin
                w = '0;
                foreach (m_q[i]) w = (w << 1) | KW'(m_q[i]);
                m_key = w; m_vld = 1; m_q.delete();
                if (m_wc < MW) m_wc++;
            end
        end
    endfunction

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_outputs(input string tag);
        check({tag, ".scan_key"},   64'(kif.scan_key),       64'(m_key));
        check({tag, ".valid"},      64'(kif.key_word_valid), 64'(m_vld));
        check({tag, ".word_count"}, 64'(kif.word_count),     64'(m_wc));
        check({tag, ".locked"},     64'(kif.locked),         64'(m_locked));
        check({tag, ".unlocked"},   64'(kif.unlocked),       64'(m_unl));
    endfunction

    task automatic step(input logic sin, input logic sh, input logic ab, input logic un);
        kif.key_sin = sin; kif.key_shift = sh; kif.key_abort = ab; kif.scan_unlock = un;
        @(posedge clk);
        model_step(sin, sh, ab, un);
        #1;
        cyc++;
        if (kif.key_word_valid === 1'b1) begin
            n_valid++;
            vq.push_back(cyc);
        end
        check_outputs("cyc");
    endtask

    task automatic shift_word(input logic [KW-1:0] w);
        for (int i = KW - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0, 1'b0);
    endtask

    // Drops reset asynchronously mid-cycle, checks immediately, releases at a negedge.
    task automatic do_reset();
        kif.key_sin = 0; kif.key_shift = 0; kif.key_abort = 0; kif.scan_unlock = 0;
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_outputs("reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int            pre;
        bit            abort;
        logic [KW-1:0] word;
        logic [KW-1:0] exp_key;
        int            exp_wc;
    } vec_t;

    vec_t          vecs[4];
    logic [KW-1:0] seq8[8];
    int            nv0;

    initial begin
        vecs[0] = '{pre: 0,  abort: 1'b0, word: 32'hEF012345, exp_key: 32'hEF012345, exp_wc: 1};
        vecs[1] = '{pre: 17, abort: 1'b1, word: 32'h6789ABCD, exp_key: 32'h6789ABCD, exp_wc: 2};
        vecs[2] = '{pre: 5,  abort: 1'b1, word: 32'h00000001, exp_key: 32'h00000001, exp_wc: 3};
        vecs[3] = '{pre: 0,  abort: 1'b0, word: 32'hFFFFFFFF, exp_key: 32'hFFFFFFFF, exp_wc: 4};
        seq8 = '{32'hEF012345, 32'h6789ABCD, 32'hEF012345, 32'h7891ABCD,
                 32'h3D4E5F60, 32'hFF8A0B2C, 32'hFA1BC49D, 32'h87A5E932};

        // Vector table: optional partial word + abort, then a full word.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int v = 0; v < 4; v++) begin
            for (int b = 0; b < vecs[v].pre; b++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
            if (vecs[v].abort) step(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
            shift_word(vecs[v].word);
            check("tbl.valid", 64'(kif.key_word_valid), 64'd1);
            check("tbl.key",   64'(kif.scan_key),       64'(vecs[v].exp_key));
            check("tbl.wc",    64'(kif.word_count),     64'(vecs[v].exp_wc));
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("tbl.idle", 64'(kif.scan_key), 64'(IDLE));
        end

        // Back-to-back words, comparator unlock, then shifts ignored.
        do_reset();
        vq.delete();
        foreach (seq8[k]) shift_word(seq8[k]);
        check("b2b.count", 64'(vq.size()), 64'd8);
        for (int i = 1; i < vq.size(); i++) check("b2b.spacing", 64'(vq[i] - vq[i-1]), 64'd32);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("b2b.unlocked", 64'(kif.unlocked), 64'd1);
        nv0 = n_valid;
        for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
        check("b2b.no_valid_after_unlock", 64'(n_valid - nv0), 64'd0);

        // Reset at bit 20: partial word lost, a full word needed afterwards.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        nv0 = n_valid;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst.no_early_valid", 64'(n_valid - nv0), 64'd0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst.full_word_valid", 64'(kif.key_word_valid), 64'd1);

        // Word budget: lockout when enabled, saturating count otherwise.
        do_reset();
        nv0 = n_valid;
        if (LOCKOUT) begin
            for (int w = 0; w < MW; w++) shift_word(32'h00000001);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            check("lock.locked", 64'(kif.locked), 64'd1);
            foreach (seq8[k]) shift_word(seq8[k]);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("lock.valids", 64'(n_valid - nv0), 64'(MW));
            check("lock.still_locked", 64'(kif.unlocked), 64'd0);
        end else begin
            for (int w = 0; w < 20; w++) shift_word(32'h00000001);
            check("nolock.valids", 64'(n_valid - nv0), 64'd20);
            check("nolock.wc_sat", 64'(kif.word_count), 64'(MW));
            check("nolock.locked", 64'(kif.locked), 64'd0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1499) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scan_key_deserializer.md
# scan_key_deserializer

Upstream feeder for the scan-protection unlock comparator. It shifts the scan-unlock key in serially from the test port, one bit per strobe, MSB first, and assembles it into KEY_WIDTH-bit words. Each completed word is presented for exactly one clock with a valid pulse; between words the output holds a non-matching idle value. It also watches the comparator's unlock result, stops accepting bits once unlocked, and optionally locks out after too many words.

## Interface
- KEY_WIDTH, 32: bits per key word; must equal the comparator's word width.
- MAX_WORDS, 12: word budget before lockout; must be at least the comparator's word count.
- IDLE_WORD, 0: value driven on scan_key when no word is being presented; must not equal any key word.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_sin  in  1  serial key data; sampled on rising clk when key_shift=1.
- key_shift  in  1  shift strobe; one bit accepted per high cycle.
- key_abort  in  1  discards the partially shifted word (bit counter and shift register cleared).
- scan_unlock  in  1  unlock status returned by the downstream comparator.
- scan_key  out  KEY_WIDTH  word to the comparator; IDLE_WORD except during the present cycle.
- key_word_valid  out  1  high for exactly the one cycle a word is presented.
- word_count  out  $clog2(MAX_WORDS+1)  words delivered since reset; saturates at MAX_WORDS.
- locked  out  1  lockout active; sticky until reset.
- unlocked  out  1  registered copy of scan_unlock; sticky.

## Operation
- States: SHIFT, DONE, LOCKED. Presentation is a one-cycle output register event inside SHIFT, not a separate state.
- SHIFT, on key_shift=1:
  - shift register becomes {shreg[KEY_WIDTH-2:0], key_sin}.
  - bit_cnt increments.
  - On the KEY_WIDTH-th bit, the completed word (including that bit) loads into scan_key, key_word_valid=1, bit_cnt returns to 0, and word_count increments (saturating).
- Presentation has no bubble: a key_shift in the present cycle is taken as bit 0 of the next word.
- key_abort=1 clears shreg and bit_cnt. It has priority over a simultaneous key_shift, and that bit is dropped. It does not affect an output word already being presented, word_count, or state.
- scan_unlock=1, sampled in any state other than LOCKED:
  - next state DONE; unlocked=1.
  - shreg and bit_cnt cleared; all later key_shift ignored.
  - scan_key=IDLE_WORD, key_word_valid=0.
- DONE and LOCKED exit only on reset.
- If scan_unlock and a lockout condition occur in the same cycle, unlock wins.
- Widths: bit_cnt is $clog2(KEY_WIDTH)+1 bits; word_count never wraps.

## Timing
- Reset values: scan_key=IDLE_WORD; key_word_valid=0; word_count=0; locked=0; unlocked=0; state SHIFT; shreg=0; bit_cnt=0.
- Latency:
  - Last bit sampled at edge N: scan_key and key_word_valid are valid from edge N to edge N+1.
  - At edge N+1, scan_key returns to IDLE_WORD unless another word completes at that edge (only possible when KEY_WIDTH=1).
  - The comparator registers the match at edge N+1.
- unlocked follows scan_unlock one cycle later.
- Asserting rst_n low mid-word or mid-present forces all reset values immediately (asynchronous); the partial word is lost.

## Configuration
- SCAN_KEY_LOCKOUT_EN defined:
  - When word_count==MAX_WORDS, unlocked=0, scan_unlock=0, and key_shift=1 (the first bit of word MAX_WORDS+1), the next state is LOCKED and locked=1. That bit is not shifted.
  - LOCKED ignores key_shift and key_abort, holds scan_key=IDLE_WORD, and ignores scan_unlock.
- SCAN_KEY_LOCKOUT_EN undefined:
  - No LOCKED state; locked is tied to 0.
  - word_count still saturates; word delivery is unlimited.

## Test plan
- Reset then shift 32 bits of 0xEF012345 MSB first: scan_key=0xEF012345 and key_word_valid=1 for exactly one cycle after the 32nd bit; IDLE_WORD=0 before and after; word_count=1.
- Back-to-back words 0xEF012345, 0x6789ABCD, 0xEF012345, 0x7891ABCD, 0x3D4E5F60, 0xFF8A0B2C, 0xFA1BC49D, 0x87A5E932 with key_shift held high continuously: eight single-cycle valid pulses 32 cycles apart; the comparator's scan_unlock rises; unlocked=1 one cycle later; further key_shift produces no valid.
- Shift 17 bits, pulse key_abort together with key_shift, then shift 32 bits of 0x6789ABCD: the delivered word is exactly 0x6789ABCD; word_count increments by 1 only.
- SCAN_KEY_LOCKOUT_EN, MAX_WORDS=12: deliver 12 wrong words (0x00000001), then one more key_shift: locked=1 the next cycle; no further valid; a correct key sequence is ignored until rst_n.
- SCAN_KEY_LOCKOUT_EN undefined: deliver 20 wrong words: locked stays 0; word_count saturates at 12; 20 valid pulses.
- Drop rst_n at bit 20 of a word: all outputs at reset values asynchronously; after release, a full 32-bit word is required before the next valid.
